// File: rtl/lift_fifo.sv
// rtl/lift_fifo.sv - parametrised sample FIFO for the DWT lifting datapath
module lift_fifo #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             rd_acc;
    logic             wr_acc;
    logic             rd_go;
    logic             wr_go;
    logic             ovf_set;
    logic             udf_set;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A read frees the head slot, so a full FIFO still accepts a paired write.
    assign rd_acc  = rd_en && !empty;
    assign wr_acc  = wr_en && (!full || rd_acc);
    assign rd_go   = rd_acc && !flush;
    assign wr_go   = wr_acc && !flush;
    assign ovf_set = wr_en && !wr_acc && !flush;
    assign udf_set = rd_en && empty && !flush;

    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_go) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_go) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({wr_go, rd_go})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Error flags are sticky; a new error event beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             dv_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else if (flush) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dv_q <= rd_go;
                    if (rd_go) begin
                        dout_q <= mem[rd_ptr];
                    end
                end
            end

            assign data_out   = dout_q;
            assign dout_valid = dv_q;
        end else begin : g_fwft
            assign data_out   = empty ? '0 : mem[rd_ptr];
            assign dout_valid = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_lift_fifo.sv
// tb/tb_lift_fifo.sv - randomized scoreboard bench for lift_fifo in three configurations
module tb_lift_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] data_in = '0;

    logic [15:0] dout [3];
    logic        dv [3];
    logic        full [3];
    logic        empty [3];
    logic        afull [3];
    logic        aempty [3];
    logic [2:0]  cnt [3];
    logic        ovf [3];
    logic        udf [3];

    int total = 0;
    int bad = 0;

    // Instance 0: depth 4 standard, 1: depth 5 standard, 2: depth 4 FWFT.
    int dep [3]  = '{4, 5, 4};
    int afth [3] = '{3, 3, 3};
    int aeth [3] = '{1, 2, 1};

    int          m_cnt [3];
    logic [15:0] m_dat [3][8];
    bit          m_ovf [3];
    bit          m_udf [3];
    logic [15:0] m_last [3];
    logic [15:0] exp0 [$];
    logic [15:0] exp1 [$];

    always #5 clk = ~clk;

    lift_fifo #(.WIDTH(16), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_d4 (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .clr_err(clr_err), .data_out(dout[0]), .dout_valid(dv[0]),
        .full(full[0]), .empty(empty[0]), .almost_full(afull[0]), .almost_empty(aempty[0]),
        .count(cnt[0]), .overflow(ovf[0]), .underflow(udf[0]));

    lift_fifo #(.WIDTH(16), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(0)) u_d5 (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .clr_err(clr_err), .data_out(dout[1]), .dout_valid(dv[1]),
        .full(full[1]), .empty(empty[1]), .almost_full(afull[1]), .almost_empty(aempty[1]),
        .count(cnt[1]), .overflow(ovf[1]), .underflow(udf[1]));

    lift_fifo #(.WIDTH(16), .DEPTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .clr_err(clr_err), .data_out(dout[2]), .dout_valid(dv[2]),
        .full(full[2]), .empty(empty[2]), .almost_full(afull[2]), .almost_empty(aempty[2]),
        .count(cnt[2]), .overflow(ovf[2]), .underflow(udf[2]));

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", name, inst, act, want, $time);
        end
    endtask

    function automatic int exp_size(input int i);
        return (i == 0) ? exp0.size() : exp1.size();
    endfunction

    function automatic logic [15:0] exp_pop(input int i);
        if (i == 0) return exp0.pop_front();
        return exp1.pop_front();
    endfunction

    // Monitor: compares every instance on the falling edge against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("count", i, 32'(cnt[i]), 32'(m_cnt[i]));
            chk("full", i, 32'(full[i]), 32'(m_cnt[i] == dep[i]));
            chk("empty", i, 32'(empty[i]), 32'(m_cnt[i] == 0));
            chk("almost_full", i, 32'(afull[i]), 32'(m_cnt[i] >= afth[i]));
            chk("almost_empty", i, 32'(aempty[i]), 32'(m_cnt[i] <= aeth[i]));
            chk("overflow", i, 32'(ovf[i]), 32'(m_ovf[i]));
            chk("underflow", i, 32'(udf[i]), 32'(m_udf[i]));
            if (i == 2) begin
                chk("fwft_valid", i, 32'(dv[i]), 32'(m_cnt[i] > 0));
                chk("fwft_data", i, 32'(dout[i]), (m_cnt[i] > 0) ? 32'(m_dat[i][0]) : 32'h0);
            end else begin
                chk("dout_valid", i, 32'(dv[i]), 32'(exp_size(i) > 0));
                if (dv[i] && exp_size(i) > 0) begin
                    chk("data_out", i, 32'(dout[i]), 32'(exp_pop(i)));
                end else if (!dv[i]) begin
                    chk("data_hold", i, 32'(dout[i]), 32'(m_last[i]));
                end
            end
        end
    end

    // Reference model: each FIFO is an ordered list; a pop shifts the list down.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_cnt[i]  = 0;
                m_ovf[i]  = 1'b0;
                m_udf[i]  = 1'b0;
                m_last[i] = '0;
            end else if (flush) begin
                m_cnt[i]  = 0;
                m_last[i] = '0;
            end else begin
                bit          rd_ok;
                bit          wr_ok;
                logic [15:0] head;
                rd_ok = rd_en && (m_cnt[i] > 0);
                wr_ok = wr_en && ((m_cnt[i] < dep[i]) || rd_ok);
                if (wr_en && !wr_ok) m_ovf[i] = 1'b1;
                else if (clr_err) m_ovf[i] = 1'b0;
                if (rd_en && m_cnt[i] == 0) m_udf[i] = 1'b1;
                else if (clr_err) m_udf[i] = 1'b0;
                if (rd_ok) begin
                    head = m_dat[i][0];
                    for (int j = 0; j < 7; j++) m_dat[i][j] = m_dat[i][j+1];
                    m_cnt[i]--;
                    m_last[i] = head;
                    if (i == 0) exp0.push_back(head);
                    if (i == 1) exp1.push_back(head);
                end
                if (wr_ok) begin
                    m_dat[i][m_cnt[i]] = data_in;
                    m_cnt[i]++;
                end
            end
        end
        if (reset) begin
            exp0.delete();
            exp1.delete();
        end
    endtask

    task automatic cyc(input bit w, input bit r, input logic [15:0] d, input bit f,
                       input bit c);
        @(negedge clk);
        #1;
        reset   = 1'b0;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        flush   = f;
        clr_err = c;
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset   = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 16'hDEAD;
        flush   = 1'b0;
        clr_err = 1'b0;
        model_step();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("async_rst_count", i, 32'(cnt[i]), 32'h0);
            chk("async_rst_empty", i, 32'(empty[i]), 32'h1);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_ovf[i]  = 1'b0;
            m_udf[i]  = 1'b0;
            m_last[i] = '0;
        end
        // Fill, overflow, clear, paired write/read on full, drain, underflow.
        for (int k = 1; k <= 5; k++) cyc(1, 0, 16'(k), 0, 0);
        cyc(1, 0, 16'h00AA, 0, 0);
        cyc(0, 0, 16'h0, 0, 0);
        cyc(0, 0, 16'h0, 0, 1);
        cyc(1, 1, 16'h0055, 0, 0);
        for (int k = 0; k < 6; k++) cyc(0, 1, 16'h0, 0, 0);
        cyc(1, 1, 16'h1234, 0, 0);
        cyc(0, 0, 16'h0, 0, 1);
        cyc(0, 1, 16'h0, 0, 0);
        // Flush with a simultaneous write, then reset mid-stream.
        for (int k = 0; k < 3; k++) cyc(1, 0, 16'h0100 + 16'(k), 0, 0);
        cyc(1, 1, 16'h0BAD, 1, 0);
        cyc(0, 0, 16'h0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(1, 0, 16'h0200 + 16'(k), 0, 0);
        cyc(0, 1, 16'h0, 0, 0);
        do_reset();
        cyc(0, 0, 16'h0, 0, 0);
        // Randomized phases biased toward filling, draining and mixed traffic.
        for (int n = 0; n < 3000; n++) begin
            int ph;
            int wp;
            int rp;
            bit f;
            bit c;
            ph = (n / 150) % 3;
            wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            rp = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
            f  = ($urandom_range(99) < 2);
            c  = !f && ($urandom_range(99) < 4);
            if (n == 1700) begin
                do_reset();
            end else begin
                cyc($urandom_range(99) < wp, $urandom_range(99) < rp, 16'($urandom), f, c);
            end
        end
        cyc(0, 0, 16'h0, 0, 0);
        cyc(0, 0, 16'h0, 0, 0);
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
